// File: rtl/binary_pixel_gen.sv
// binary_pixel_gen: thresholds a grey VGA pixel stream into a binary marker
// stream with pixel coordinates, re-times HS/VS to match, and keeps per-frame
// white-pixel / frame statistics.
// Optional feature macro: RUN_FILTER_EN (horizontal opening of length MIN_RUN).
module binary_pixel_gen #(
    parameter int MIN_RUN = 3,
    parameter int WCNT_W  = 20
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              VGA_HS,
    input  logic              VGA_VS,
    input  logic [7:0]        i_GRAY,
    input  logic [7:0]        i_THRESH,
    output logic              o_VGA_HS,
    output logic              o_VGA_VS,
    output logic              BINARY_FLAG,
    output logic [15:0]       H_CNT,
    output logic [15:0]       V_CNT,
    output logic [WCNT_W-1:0] o_WHITE_CNT,
    output logic [15:0]       o_FRAME_CNT
);

    if (MIN_RUN < 2 || MIN_RUN > 8) begin : g_min_run_check
        $error("binary_pixel_gen: MIN_RUN must be within 2..8");
    end

`ifdef RUN_FILTER_EN
    localparam int unsigned LAT = 1 + 2 * (MIN_RUN - 1);
`else
    localparam int unsigned LAT = 1;
`endif

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        ok;   // pixel belongs to a frame that started after reset
        logic [15:0] h;
        logic [15:0] v;
    } side_t;

    logic [15:0] col;
    logic [15:0] row;
    logic        hs_prev;
    logic        hs_low_seen;
    logic        vs_low_seen;
    logic [15:0] hc;
    logic [15:0] vc;
    logic        raw;
    logic        bin_out;
    side_t       side_in;
    side_t       side_dly [LAT];

    // Column/row tracking. A row only advances on an HS fall once a full
    // HS low has been seen, so a line cut by reset is not counted.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            col         <= '0;
            row         <= '0;
            hs_prev     <= 1'b0;
            hs_low_seen <= 1'b0;
            vs_low_seen <= 1'b0;
        end else begin
            hs_prev     <= VGA_HS;
            hs_low_seen <= hs_low_seen | ~VGA_HS;
            vs_low_seen <= vs_low_seen | ~VGA_VS;
            if (!VGA_HS)
                col <= '0;
            else if (col != 16'hFFFF)
                col <= col + 16'd1;
            if (!VGA_VS)
                row <= '0;
            else if (hs_prev && !VGA_HS && hs_low_seen && row != 16'hFFFF)
                row <= row + 16'd1;
        end
    end

    // Current pixel coordinates, raw threshold bit and side-band bundle.
    always_comb begin
        hc         = VGA_HS ? col : '0;
        vc         = VGA_VS ? row : '0;
        raw        = VGA_HS & VGA_VS & (i_GRAY >= i_THRESH);
        side_in.hs = VGA_HS;
        side_in.vs = VGA_VS;
        side_in.ok = VGA_VS & vs_low_seen;
        side_in.h  = hc;
        side_in.v  = vc;
    end

    // Side-band delay line, same length as the binary path.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int unsigned i = 0; i < LAT; i++) side_dly[i] <= '0;
        end else begin
            side_dly[0] <= side_in;
            for (int unsigned i = 1; i < LAT; i++) side_dly[i] <= side_dly[i-1];
        end
    end

`ifdef RUN_FILTER_EN
    localparam int unsigned RUN = MIN_RUN;
    localparam int unsigned WIN = 2 * RUN - 1;

    logic [WIN-1:0] hist;       // hist[0] is the newest registered raw bit
    logic [RUN-2:0] flag_pipe;
    logic           open_bit;
    logic           seg;

    // Opening for the pixel RUN-1 behind the newest: white if any length-RUN
    // window containing it is all white. Erode and dilate are folded into one
    // window over 2*RUN-1 samples; the tail pipe pads to the full latency.
    always_comb begin
        open_bit = 1'b0;
        seg      = 1'b0;
        for (int unsigned s = 0; s < RUN; s++) begin
            seg = 1'b1;
            for (int unsigned k = 0; k < RUN; k++) seg = seg & hist[s + k];
            open_bit = open_bit | seg;
        end
    end

    // Raw history and output alignment pipe.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hist      <= '0;
            flag_pipe <= '0;
        end else begin
            hist         <= {hist[WIN-2:0], raw};
            flag_pipe[0] <= open_bit;
            for (int unsigned i = 1; i < RUN - 1; i++) flag_pipe[i] <= flag_pipe[i-1];
        end
    end

    assign bin_out = flag_pipe[RUN-2];
`else
    logic flag_q;

    // Unfiltered path: raw bit registered once.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) flag_q <= 1'b0;
        else     flag_q <= raw;
    end

    assign bin_out = flag_q;
`endif

    assign BINARY_FLAG = bin_out;
    assign o_VGA_HS    = side_dly[LAT-1].hs;
    assign o_VGA_VS    = side_dly[LAT-1].vs;
    assign H_CNT       = side_dly[LAT-1].h;
    assign V_CNT       = side_dly[LAT-1].v;

    logic              ok_prev;
    logic              frame_end;
    logic [WCNT_W-1:0] acc;
    logic [WCNT_W-1:0] acc_next;

    // Saturating white count including the current output pixel.
    always_comb begin
        frame_end = ok_prev & ~o_VGA_VS;
        acc_next  = (acc == '1) ? acc : acc + {{(WCNT_W-1){1'b0}}, bin_out};
    end

    // Frame statistics, updated on the falling edge of the delayed VS.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ok_prev     <= 1'b0;
            acc         <= '0;
            o_WHITE_CNT <= '0;
            o_FRAME_CNT <= '0;
        end else begin
            ok_prev <= side_dly[LAT-1].ok;
            if (frame_end) begin
                o_WHITE_CNT <= acc_next;
                o_FRAME_CNT <= o_FRAME_CNT + 16'd1;
            end
            acc <= o_VGA_VS ? acc_next : '0;
        end
    end

endmodule

// File: tb/tb_binary_pixel_gen.sv
// Self-checking bench for binary_pixel_gen: scoreboard of expected output
// pixels plus frame-statistics checks on a default and a narrow-counter DUT.
module tb_binary_pixel_gen;

`ifdef RUN_FILTER_EN
    localparam int L    = 5;
    localparam bit FILT = 1'b1;
`else
    localparam int L    = 1;
    localparam bit FILT = 1'b0;
`endif
    localparam int M = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       hs = 1'b0, vs = 1'b0;
    logic [7:0] gray = '0, th = '0;

    logic        o_hs, o_vs, bin;
    logic [15:0] hcnt, vcnt, fcnt;
    logic [19:0] wcnt;
    logic        s_hs, s_vs, s_bin;
    logic [15:0] s_h, s_v, s_f;
    logic [3:0]  s_w;

    binary_pixel_gen #(.MIN_RUN(M), .WCNT_W(20)) dut (
        .CLK(clk), .RST(rst), .VGA_HS(hs), .VGA_VS(vs), .i_GRAY(gray), .i_THRESH(th),
        .o_VGA_HS(o_hs), .o_VGA_VS(o_vs), .BINARY_FLAG(bin), .H_CNT(hcnt), .V_CNT(vcnt),
        .o_WHITE_CNT(wcnt), .o_FRAME_CNT(fcnt)
    );

    binary_pixel_gen #(.MIN_RUN(M), .WCNT_W(4)) dut_sat (
        .CLK(clk), .RST(rst), .VGA_HS(hs), .VGA_VS(vs), .i_GRAY(gray), .i_THRESH(th),
        .o_VGA_HS(s_hs), .o_VGA_VS(s_vs), .BINARY_FLAG(s_bin), .H_CNT(s_h), .V_CNT(s_v),
        .o_WHITE_CNT(s_w), .o_FRAME_CNT(s_f)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int stamp;
        bit b;
        int h;
        int v;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   white_exp = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", tag, got, got, want, want);
        end
    endtask

    function automatic int sat15(input int x);
        return (x > 15) ? 15 : x;
    endfunction

    // Drive one cycle of stimulus; optionally record the expected output pixel.
    task automatic px(input bit h, input bit v, input byte unsigned g, input byte unsigned t,
                      input bit push, input bit b, input int hexp, input int vexp);
        exp_t e;
        hs = h; vs = v; gray = g; th = t;
        if (push) begin
            e.stamp = cyc + 1; e.b = b; e.h = hexp; e.v = vexp;
            sb.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    // Pixel pattern generator per frame kind.
    function automatic void gen(input int kind, input int row, input int col,
                                output byte unsigned g, output byte unsigned t);
        t = 8'd128;
        g = 8'd0;
        case (kind)
            1: g = 8'd255;
            2: if ((row == 5 && (col == 10 || (col >= 20 && col <= 21) ||
                                 (col >= 30 && col <= 32) || (col >= 40 && col <= 46))) ||
                   (row == 7 && col >= 638) || (row == 8 && col == 0))
                   g = 8'd255;
            3: begin
                t = 8'd200;
                if (row == 1) begin
                    if (col < 10)      g = 8'd199;
                    else if (col < 20) g = 8'd200;
                    else if (col < 30) g = 8'd255;
                end
            end
            4: begin
                g = 8'($urandom_range(0, 255));
                t = 8'($urandom_range(0, 255));
            end
            default: ;
        endcase
    endfunction

    // One line followed by a single HS-low cycle. Expected bits: a white pixel
    // survives the filter only if its white run within the line is >= M long.
    task automatic drive_line(input int w, input int kind, input int row, input int vexp);
        byte unsigned ga[640];
        byte unsigned ta[640];
        bit rw[640];
        bit fb[640];
        int s, e;
        for (int c = 0; c < w; c++) begin
            gen(kind, row, c, ga[c], ta[c]);
            rw[c] = (ga[c] >= ta[c]);
            fb[c] = rw[c];
        end
        if (FILT) begin
            s = 0;
            while (s < w) begin
                if (!rw[s]) s++;
                else begin
                    e = s;
                    while (e < w && rw[e]) e++;
                    for (int k = s; k < e; k++) fb[k] = ((e - s) >= M);
                    s = e;
                end
            end
        end
        for (int c = 0; c < w; c++) begin
            px(1'b1, 1'b1, ga[c], ta[c], 1'b1, fb[c], c, vexp);
            white_exp += int'(fb[c]);
        end
        px(1'b0, 1'b1, 8'd0, 8'd0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic run_frame(input int w, input int r, input int kind, input int gap);
        white_exp = 0;
        for (int row = 0; row < r; row++) drive_line(w, kind, row, row);
        for (int i = 0; i < gap; i++) px(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 0, 0);
    endtask

    // Output monitor: every valid output pixel must match the next expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst) begin
            if (o_hs && o_vs) begin
                check("sb_nonempty", 64'(sb.size() > 0), 64'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("bin",     64'(bin),  64'(e.b));
                    check("h_cnt",   64'(hcnt), 64'(e.h));
                    check("v_cnt",   64'(vcnt), 64'(e.v));
                    check("latency", 64'(cyc),  64'(e.stamp + L - 1));
                end
            end else begin
                check("bin_idle", 64'(bin), 64'd0);
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 64'({o_hs, o_vs, bin, hcnt, vcnt, wcnt, fcnt}), 64'd0);
        rst = 1'b0;
        repeat (4) px(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 0, 0);

        // Counters, run filter and line-boundary pattern on 640-wide lines.
        run_frame(640, 10, 2, L + 4);
        check("pat_white",     64'(wcnt), 64'(white_exp));
        check("pat_white_sat", 64'(s_w),  64'(sat15(white_exp)));
        check("pat_frames",    64'(fcnt), 64'd1);

        // Threshold edge: 199 black, 200 and 255 white.
        run_frame(40, 3, 3, L + 4);
        check("thr_white", 64'(wcnt), 64'd20);
        check("thr_frames", 64'(fcnt), 64'd2);

        // Full 480-row frame with random pixels and per-pixel thresholds.
        run_frame(8, 480, 4, L + 4);
        check("rnd_white",     64'(wcnt), 64'(white_exp));
        check("rnd_white_sat", 64'(s_w),  64'(sat15(white_exp)));
        check("rnd_frames",    64'(fcnt), 64'd3);

        // Reset at row 100, column 300 for two cycles.
        for (int row = 0; row < 100; row++) drive_line(320, 0, row, row);
        for (int c = 0; c < 300; c++) px(1'b1, 1'b1, 8'd0, 8'd128, 1'b1, 1'b0, c, 100);
        rst = 1'b1;
        sb.delete();
        #1;
        check("rst_outs_main", 64'({o_hs, o_vs, bin, hcnt, vcnt, wcnt, fcnt}), 64'd0);
        check("rst_outs_sat",  64'({s_hs, s_vs, s_bin, s_h, s_v, s_w, s_f}), 64'd0);
        px(1'b1, 1'b1, 8'd0, 8'd128, 1'b0, 1'b0, 0, 0);
        check("rst_hold_main", 64'({o_hs, o_vs, bin, hcnt, vcnt, wcnt, fcnt}), 64'd0);
        px(1'b1, 1'b1, 8'd0, 8'd128, 1'b0, 1'b0, 0, 0);
        rst = 1'b0;
        for (int c = 302; c < 320; c++) px(1'b1, 1'b1, 8'd0, 8'd128, 1'b1, 1'b0, c - 302, 0);
        px(1'b0, 1'b1, 8'd0, 8'd0, 1'b0, 1'b0, 0, 0);
        drive_line(320, 0, 101, 0);
        drive_line(320, 0, 102, 1);
        for (int i = 0; i < L + 4; i++) px(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 0, 0);
        check("rst_frames",     64'(fcnt), 64'd0);
        check("rst_frames_sat", 64'(s_f),  64'd0);

        // Saturation: all-white 4x8 frame, then all black.
        run_frame(4, 8, 1, L + 4);
        check("white_main", 64'(wcnt), 64'(white_exp));
        check("white_sat",  64'(s_w),  64'd15);
        check("white_frm",  64'(fcnt), 64'd1);
        run_frame(4, 8, 0, L + 4);
        check("black_main", 64'(wcnt), 64'd0);
        check("black_sat",  64'(s_w),  64'd0);
        check("black_frm",  64'(s_f),  64'd2);

        // Back-to-back frames separated by a single VS-low cycle.
        run_frame(4, 8, 4, 1);
        run_frame(4, 8, 4, L + 4);
        check("b2b_white",  64'(wcnt), 64'(white_exp));
        check("b2b_frames", 64'(fcnt), 64'd4);

        repeat (L + 2) px(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 0, 0);
        check("sb_drain", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
